reset_sequencer: RTL and testbench

//  Central reset controller: takes the clock-synchronised system reset plus

---
 rtl/reset_sequencer_pkg.sv | 22 ++
 rtl/reset_sequencer_button_debouncer.sv | 56 +++++
 rtl/reset_sequencer.sv | 135 +++++++++++++
 tb/tb_reset_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared encodings for the reset sequencer: reset-cause codes and sequencer states.
// The CSR block imports this package to decode rst_cause.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        RST_CAUSE_POR = 2'b00,
        RST_CAUSE_BTN = 2'b01,
        RST_CAUSE_SW  = 2'b10,
        RST_CAUSE_WDT = 2'b11
    } rst_cause_e;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'b00,
        ST_RELEASE = 2'b01,
        ST_RUN     = 2'b10
    } seq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_button_debouncer.sv
// Push-button conditioning: 2-flop synchroniser, stability counter and a
// one-cycle pulse on the debounced press (1->0) edge.
module button_debouncer
    import reset_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn_n,
    output logic btn_level,
    output logic btn_evt
);

    localparam int CNT_W = max_int($clog2(DEBOUNCE_CYCLES + 1), 1);

    logic             sync_meta;
    logic             sync_out;
    logic [CNT_W-1:0] stable_cnt;
    logic             differs;
    logic             flip;

    assign differs = (sync_out != btn_level);
    assign flip    = differs && (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Synchroniser resets to the released level so no spurious press is seen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_meta <= 1'b1;
            sync_out  <= 1'b1;
        end else begin
            sync_meta <= btn_n;
            sync_out  <= sync_meta;
        end
    end

    // Any sample matching the current level restarts the stability count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stable_cnt <= '0;
            btn_level  <= 1'b1;
            btn_evt    <= 1'b0;
        end else begin
            btn_evt <= flip && !sync_out;
            if (flip) begin
                btn_level  <= sync_out;
                stable_cnt <= '0;
            end else if (differs) begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: releases NUM_DOMAINS reset domains in order, one
// every RELEASE_GAP cycles, and restarts on button, software or watchdog events.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS     = 3,
    parameter int RELEASE_GAP     = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   btn_n,
    input  logic                   sw_rst_req,
    input  logic                   wdt_expire,
    output logic [NUM_DOMAINS-1:0] domain_rstn,
    output logic                   ready,
    output logic [1:0]             rst_cause
);

    localparam int CNT_W = max_int($clog2(max_int(RELEASE_GAP, DEBOUNCE_CYCLES) + 1), 1);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    logic btn_level;
    logic btn_evt;
    logic reset_event;

    seq_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   ready_q, ready_d;
    rst_cause_e             cause_q, cause_d;
    logic                   gap_done;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button_debouncer (
        .clk      (clk),
        .rstn     (rstn),
        .btn_n    (btn_n),
        .btn_level(btn_level),
        .btn_evt  (btn_evt)
    );

    assign reset_event = wdt_expire | btn_evt | sw_rst_req;
    assign gap_done    = (cnt_q == CNT_W'(RELEASE_GAP - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            ready_q <= 1'b0;
            cause_q <= RST_CAUSE_POR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            ready_q <= ready_d;
            cause_q <= cause_d;
        end
    end

    // A reset event overrides everything, including a release due this cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        ready_d = ready_q;
        cause_d = cause_q;

        if (reset_event) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            ready_d = 1'b0;
            if (wdt_expire) begin
                cause_d = RST_CAUSE_WDT;
            end else if (btn_evt) begin
                cause_d = RST_CAUSE_BTN;
            end else begin
                cause_d = RST_CAUSE_SW;
            end
        end else begin
            case (state_q)
                ST_HOLD: begin
                    dom_d   = '0;
                    ready_d = 1'b0;
                    if (!btn_level) begin
                        cnt_d = '0;
                    end else if (gap_done) begin
                        dom_d[0] = 1'b1;
                        cnt_d    = '0;
                        idx_d    = IDX_W'(1);
                        state_d  = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (gap_done) begin
                        dom_d[idx_q] = 1'b1;
                        cnt_d        = '0;
                        if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    ready_d = 1'b1;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dom_d   = '0;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    assign domain_rstn = dom_q;
    assign ready       = ready_q;
    assign rst_cause   = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized button/strobe
// traffic, compared every cycle against a release-progress model.
module tb_reset_sequencer;

    localparam int NUM = 3;
    localparam int GAP = 4;
    localparam int DEB = 8;
    localparam int SAT = 10000;

    logic           clk;
    logic           rstn;
    logic           btn_n;
    logic           sw_rst_req;
    logic           wdt_expire;
    logic [NUM-1:0] domain_rstn;
    logic           ready;
    logic [1:0]     rst_cause;

    int total_cnt = 0;
    int bad_cnt   = 0;

    // Model: cycles of progress since restart, debounced level, pending press pulse.
    int       m_prog;
    bit       m_level;
    bit       m_evt;
    bit [1:0] m_cause;
    bit       hist[$];

    reset_sequencer #(
        .NUM_DOMAINS    (NUM),
        .RELEASE_GAP    (GAP),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .btn_n      (btn_n),
        .sw_rst_req (sw_rst_req),
        .wdt_expire (wdt_expire),
        .domain_rstn(domain_rstn),
        .ready      (ready),
        .rst_cause  (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total_cnt++;
        if (observed !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_prog  = 0;
        m_level = 1'b1;
        m_evt   = 1'b0;
        m_cause = 2'b00;
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b1);
    endtask

    // The button is seen through two flops, so the sample judged at an edge
    // was driven two cycles earlier; a flip needs DEB such samples all opposite.
    task automatic modelStep(input bit sw, input bit wdt, input bit btn);
        bit all_opp;
        if (sw || wdt || m_evt) begin
            m_prog  = 0;
            m_cause = wdt ? 2'b11 : (m_evt ? 2'b01 : 2'b10);
        end else if (m_prog < GAP && !m_level) begin
            m_prog = 0;
        end else if (m_prog < SAT) begin
            m_prog++;
        end
        hist.push_front(btn);
        void'(hist.pop_back());
        all_opp = 1'b1;
        for (int i = 2; i <= DEB + 1; i++) begin
            if (hist[i] == m_level) all_opp = 1'b0;
        end
        m_evt = all_opp && m_level;
        if (all_opp) m_level = !m_level;
    endtask

    task automatic checkModel();
        int released;
        logic [NUM-1:0] exp_dom;
        released = m_prog / GAP;
        if (released > NUM) released = NUM;
        exp_dom = NUM'((1 << released) - 1);
        checkOutput("domain_rstn", 32'(domain_rstn), 32'(exp_dom));
        checkOutput("ready", 32'(ready), 32'(m_prog >= NUM * GAP + 1));
        checkOutput("rst_cause", 32'(rst_cause), 32'(m_cause));
    endtask

    task automatic applyStimulus(input bit sw, input bit wdt, input bit btn);
        sw_rst_req = sw;
        wdt_expire = wdt;
        btn_n      = btn;
        modelStep(sw, wdt, btn);
        @(posedge clk);
        #1;
        checkModel();
    endtask

    // Called just after a posedge: reset lands between clock edges.
    task automatic asyncReset();
        #2;
        rstn       = 1'b0;
        btn_n      = 1'b1;
        sw_rst_req = 1'b0;
        wdt_expire = 1'b0;
        #1;
        checkOutput("async_domain_rstn", 32'(domain_rstn), 32'd0);
        checkOutput("async_ready", 32'(ready), 32'd0);
        checkOutput("async_rst_cause", 32'(rst_cause), 32'd0);
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        bit btn_val;
        int seg_left;
        clk        = 1'b0;
        rstn       = 1'b0;
        btn_n      = 1'b1;
        sw_rst_req = 1'b0;
        wdt_expire = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_domain_rstn", 32'(domain_rstn), 32'd0);
        checkOutput("reset_ready", 32'(ready), 32'd0);
        checkOutput("reset_rst_cause", 32'(rst_cause), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] power-on sequence");
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] software reset from RUN");
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (16) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] glitchy then stable button");
        for (int g = 0; g < 3; g++) begin
            repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b1);
        end
        repeat (12) applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (40) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] simultaneous watchdog and software request");
        applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (16) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] software request on the domain-2 release cycle");
        applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (11) applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("mid_seq_domain_rstn", 32'(domain_rstn), 32'd0);
        repeat (16) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] asynchronous reset mid-RUN");
        asyncReset();
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        btn_val  = 1'b1;
        seg_left = 30;
        for (int c = 0; c < 3000; c++) begin
            if (seg_left == 0) begin
                btn_val  = !btn_val;
                seg_left = btn_val ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 14));
            end
            seg_left--;
            applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 89) == 0, btn_val);
            if ($urandom_range(0, 499) == 0) asyncReset();
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
